// File: rtl/pipeline_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// Module : pipeline_control_unit_pkg
// Brief  : Shared state encoding and sizing helper for the pipeline control
//          unit and its counter sub-block.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pipeline_control_unit_pkg;

  // Run FSM states; the numeric values are visible on the debug readout port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } pcu_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    cnt_width = (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_control_unit_counter.sv
// ---------------------------------------------------------------------------
// Module : pipeline_control_unit_counter
// Brief  : Small load / increment / decrement counter. Increment saturates
//          at SAT_MAX, decrement saturates at zero; load has priority.
// Ports  : i_clk, i_rst (async, active-high), i_load, i_load_val, i_inc,
//          i_dec, o_zero (count == 0), o_sat (count == SAT_MAX)
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_control_unit_counter #(
  parameter int WIDTH   = 4,
  parameter int SAT_MAX = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_sat
);

  localparam logic [WIDTH-1:0] c_sat = WIDTH'(SAT_MAX);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc && (r_count != c_sat)) begin
      r_count <= r_count + WIDTH'(1);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);
  assign o_sat  = (r_count == c_sat);

endmodule

`default_nettype wire

// File: rtl/pipeline_control_unit.sv
// ---------------------------------------------------------------------------
// Module : pipeline_control_unit
// Brief  : Sequences the 5-stage pipeline: merges hazard stalls, ID-stage
//          redirects and debug run/step/halt into per-stage enables, flush
//          and bubble controls. Owns the run FSM, HALT drain and a stall
//          watchdog.
// Ports  : i_clk, i_rst (async, active-high)
//          i_start, i_step            debug run / single-step pulses
//          i_stall_req                hazard stall (same-cycle)
//          i_jump_taken               ID-stage redirect
//          i_halt_decoded             HALT opcode in ID
//          o_pc_write, o_if_id_write  front-end register enables
//          o_if_id_flush              zero IF_ID on next edge
//          o_id_ex_bubble             NOP into ID_EX on next edge
//          o_pipe_en                  enable for ID_EX / EX_MEM / MEM_WB
//          o_halted                   pipeline drained (registered)
//          o_stall_timeout            sticky watchdog error (registered)
//          o_state                    FSM state for debug readout
// Config : PIPE_CTRL_STATS_EN adds o_cycle_cnt / o_stall_cnt statistics.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int MAX_STALL    = 16,
  parameter int CNT_W        = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_step,
  input  logic       i_stall_req,
  input  logic       i_jump_taken,
  input  logic       i_halt_decoded,
  output logic       o_pc_write,
  output logic       o_if_id_write,
  output logic       o_if_id_flush,
  output logic       o_id_ex_bubble,
  output logic       o_pipe_en,
  output logic       o_halted,
  output logic       o_stall_timeout,
  output logic [2:0] o_state
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  localparam int c_drain_w = cnt_width(DRAIN_CYCLES);
  localparam int c_wd_w    = cnt_width(MAX_STALL);
  // The counter is checked for zero while in DRAIN, so loading N-1 gives N
  // drain cycles.
  localparam logic [c_drain_w-1:0] c_drain_load = c_drain_w'(DRAIN_CYCLES - 1);

  pcu_state_e r_state;
  logic       r_halted;
  logic       r_timeout;

  logic w_run_like;
  logic w_halt_go;
  logic w_drain_zero;
  logic w_wd_sat;
  logic w_wd_inc;
  logic w_unused_drain_sat;
  logic w_unused_wd_zero;

  assign w_run_like = (r_state == ST_RUN) || (r_state == ST_STEP);
  // HALT seen under a stall is not acted on; it re-presents once the stall clears.
  assign w_halt_go  = w_run_like && i_halt_decoded && !i_stall_req;
  assign w_wd_inc   = o_pipe_en && i_stall_req;

  // Stage controls are combinational so a stall takes effect in the same cycle.
  always_comb begin
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_en      = 1'b0;
    case (r_state)
      ST_RUN, ST_STEP: begin
        o_pipe_en = 1'b1;
        if (i_stall_req) begin
          // Stall beats jump: the redirect is re-presented next cycle.
          o_id_ex_bubble = 1'b1;
        end else begin
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
          o_if_id_flush = i_jump_taken;
        end
      end
      ST_DRAIN: begin
        o_pipe_en      = 1'b1;
        o_id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_halted  <= (r_state == ST_HALTED);
      r_timeout <= r_timeout | w_wd_sat;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RUN;
          end else if (i_step) begin
            r_state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (w_halt_go) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_STEP: begin
          r_state <= w_halt_go ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (w_drain_zero) begin
            r_state <= ST_HALTED;
          end
        end
        ST_HALTED: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pipeline_control_unit_counter #(
    .WIDTH   (c_drain_w),
    .SAT_MAX (DRAIN_CYCLES)
  ) u_drain_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_halt_go),
    .i_load_val (c_drain_load),
    .i_inc      (1'b0),
    .i_dec      (r_state == ST_DRAIN),
    .o_zero     (w_drain_zero),
    .o_sat      (w_unused_drain_sat)
  );

  // Watchdog: cleared by any stall-free cycle, counts enabled stall cycles.
  pipeline_control_unit_counter #(
    .WIDTH   (c_wd_w),
    .SAT_MAX (MAX_STALL)
  ) u_watchdog (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (!i_stall_req),
    .i_load_val ('0),
    .i_inc      (w_wd_inc),
    .i_dec      (1'b0),
    .o_zero     (w_unused_wd_zero),
    .o_sat      (w_wd_sat)
  );

`ifdef PIPE_CTRL_STATS_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Both counters advance only on enabled cycles, so they freeze in IDLE/HALTED.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (o_pipe_en) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      if (w_wd_inc) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
  assign o_stall_cnt = r_stall_cnt;
`else
  localparam int c_unused_cnt_w = CNT_W;
`endif

  assign o_halted        = r_halted;
  assign o_stall_timeout = r_timeout;
  assign o_state         = r_state;

endmodule

`default_nettype wire
